// File: rtl/size_exploration_harness.sv
// Serial-load three-operand adder harness: MSB-first operand shift, launch-edge triggered
// fixed-latency RUN phase, byte-selectable readout. Optional macro: HARNESS_RUN_COUNTER_EN.
//
// state | meaning
// IDLE  | reset state, nothing loaded yet
// LOAD  | operands being shifted in
// RUN   | stage counter counting down to the result
// DONE  | result registered, waiting for new shift or launch
module size_exploration_harness #(
  parameter int WIDTH       = 8,
  parameter int NUM_OPS     = 3,
  parameter int PIPE_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam int              SW       = WIDTH + 2;
  localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);
  localparam logic [3:0]      STAGES   = 4'(PIPE_STAGES);

  state_t             state;
  logic [WIDTH-1:0]   op [NUM_OPS];
  logic [WIDTH-1:0]   op_ext [3];
  logic [CW-1:0]      shift_cnt;
  logic [3:0]         stage_cnt;
  logic [31:0]        result;
  logic [15:0]        run_cnt;
  logic               launch_q;
  logic [SW-1:0]      sum;
  logic               shift_en;
  logic               launch_edge;
  logic               count_full;
  logic               do_shift;
  logic [2:0]         sel;
  logic               unused_ok;

  assign shift_en    = ui_in[3];
  assign launch_edge = ui_in[4] & ~launch_q;
  assign sel         = ui_in[7:5];
  assign count_full  = (shift_cnt == CNT_FULL);
  assign do_shift    = ena && shift_en && !launch_edge && (state != RUN);
  assign unused_ok   = &{1'b0, uio_in, ui_in[2:0]};

  // Channels beyond NUM_OPS contribute zero to the sum.
  always_comb begin
    for (int i = 0; i < 3; i++) op_ext[i] = '0;
    for (int i = 0; i < NUM_OPS; i++) op_ext[i] = op[i];
  end

  assign sum = SW'(op_ext[0]) + SW'(op_ext[1]) + SW'(op_ext[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) op[i] <= '0;
    end else if (do_shift) begin
      for (int i = 0; i < NUM_OPS; i++) op[i] <= {op[i][WIDTH-2:0], ui_in[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_cnt <= '0;
      stage_cnt <= '0;
      result    <= '0;
      launch_q  <= 1'b0;
    end else if (ena) begin
      launch_q <= ui_in[4];
      case (state)
        IDLE, DONE: begin
          if (launch_edge) begin
            state     <= RUN;
            stage_cnt <= STAGES;
          end else if (shift_en) begin
            state     <= LOAD;
            shift_cnt <= CW'(1);
          end
        end
        LOAD: begin
          if (launch_edge) begin
            state     <= RUN;
            stage_cnt <= STAGES;
          end else if (shift_en && !count_full) begin
            shift_cnt <= shift_cnt + CW'(1);
          end
        end
        RUN: begin
          stage_cnt <= stage_cnt - 4'd1;
          if (stage_cnt == 4'd1) begin
            result <= 32'(sum);
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HARNESS_RUN_COUNTER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (ena && state == RUN && stage_cnt == 4'd1) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end
`else
  assign run_cnt = 16'h0;
`endif

  always_comb begin
    uo_out = 8'h00;
    case (sel)
      3'd0: uo_out = result[7:0];
      3'd1: uo_out = result[15:8];
      3'd2: uo_out = result[23:16];
      3'd3: uo_out = result[31:24];
      3'd4: uo_out = run_cnt[7:0];
      3'd5: uo_out = run_cnt[15:8];
      default: uo_out = 8'h00;
    endcase
  end

  assign uio_out = {run_cnt[3:0], count_full, (state == DONE), state};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_size_exploration_harness.sv
// Bench for size_exploration_harness: fixed vector table, directed corner sequences and
// randomized serial loads checked against an arithmetic operand/result model.
module tb_size_exploration_harness;
  localparam int WIDTH = 8;
  localparam int NUM_OPS = 3;
  localparam int PIPE = 2;
  localparam longint MASK = (64'd1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [2:0] d, sel;
  logic sh, la;

  assign ui_in = {sel, la, sh, d};

  size_exploration_harness #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .PIPE_STAGES(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int runs = 0;
  longint mo [3];

  typedef struct {
    logic [7:0] a, b, c;
    logic [7:0] e0, e1, e2;
  } vec_t;
  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] s, output logic [7:0] v);
    sel = s;
    #1;
    v = uo_out;
  endtask

  function automatic logic [15:0] exp_run();
`ifdef HARNESS_RUN_COUNTER_EN
    return 16'(runs);
`else
    return 16'h0;
`endif
  endfunction

  function automatic void model_shift(input logic [2:0] dd);
    for (int i = 0; i < NUM_OPS; i++) mo[i] = ((mo[i] << 1) | longint'(dd[i])) & MASK;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) mo[i] = 0;
    runs = 0;
  endfunction

  task automatic shift_ops(input logic [31:0] a, b, c, input int hi, input int lo);
    for (int k = hi; k >= lo; k--) begin
      d = {c[k], b[k], a[k]};
      sh = 1'b1; la = 1'b0; ena = 1'b1;
      step();
      model_shift(d);
    end
    sh = 1'b0; d = 3'd0;
  endtask

  // Launch, then expect RUN for PIPE-1 cycles and DONE exactly PIPE cycles after launch.
  // Shift/launch inputs toggle randomly during RUN and must be ignored.
  task automatic run_op(input string tag, input logic sh_l, input logic [2:0] d_l);
    la = 1'b1; sh = sh_l; d = d_l; ena = 1'b1;
    step();
    check({tag, " launch->RUN"}, 32'(uio_out[1:0]), 32'd2);
    for (int k = 0; k < PIPE; k++) begin
      sh = 1'($urandom); la = 1'($urandom); d = 3'($urandom);
      step();
      if (k < PIPE - 1) check({tag, " still RUN"}, 32'(uio_out[1:0]), 32'd2);
    end
    check({tag, " DONE latency"}, 32'(uio_out[1:0]), 32'd3);
    la = 1'b0; sh = 1'b0; d = 3'd0;
    runs++;
  endtask

  task automatic check_result(input string tag, input longint exp);
    logic [7:0] v;
    logic [31:0] e;
    e = 32'(exp);
    for (int s = 0; s < 4; s++) begin
      rd(3'(s), v);
      check({tag, " result byte"}, 32'(v), 32'(e[8*s +: 8]));
    end
  endtask

  initial begin
    logic [7:0] v;
    logic [15:0] rc;
    int cnt, nsh, done_sh, r;
    logic first;

    rst_n = 1'b0; ena = 1'b1; uio_in = 8'h00;
    sh = 1'b0; la = 1'b0; d = 3'd0; sel = 3'd0;
    model_reset();
    #12;
    for (int s = 0; s < 8; s++) begin
      rd(3'(s), v);
      check("reset uo_out", 32'(v), 32'h0);
    end
    check("reset uio_out", 32'(uio_out), 32'h0);
    check("uio_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b1;
    step();
    check("post-reset uio_out", 32'(uio_out), 32'h0);

    vt[0] = '{8'h12, 8'h34, 8'h56, 8'h9C, 8'h00, 8'h00};
    vt[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'h02, 8'h00};
    vt[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vt[3] = '{8'h01, 8'h02, 8'h03, 8'h06, 8'h00, 8'h00};
    vt[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h01, 8'h00};
    for (int i = 0; i < 5; i++) begin
      shift_ops(32'(vt[i].a), 32'(vt[i].b), 32'(vt[i].c), 7, 0);
      check("table LOAD state", 32'(uio_out[3:0]), 32'b1001);
      run_op("table", 1'b0, 3'd0);
      rd(3'd0, v); check("table sel0", 32'(v), 32'(vt[i].e0));
      rd(3'd1, v); check("table sel1", 32'(v), 32'(vt[i].e1));
      rd(3'd2, v); check("table sel2", 32'(v), 32'(vt[i].e2));
      rc = exp_run();
      check("table status", 32'(uio_out), 32'({rc[3:0], 4'b1111}));
    end
    rd(3'd4, v); check("run count lo after table", 32'(v), 32'(exp_run() & 16'hFF));

    // Simultaneous shift and launch in LOAD: launch wins, operands untouched.
    shift_ops(32'h11, 32'h22, 32'h33, 7, 0);
    run_op("shift+launch", 1'b1, 3'b111);
    check_result("shift+launch", 64'h66);

    // ena low while shift_en high must freeze operands and shift count.
    shift_ops(32'hC3, 32'h5A, 32'h0F, 7, 4);
    ena = 1'b0; sh = 1'b1; d = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      check("ena hold status", 32'(uio_out[3:0]), 32'b0001);
    end
    ena = 1'b1; sh = 1'b0;
    shift_ops(32'hC3, 32'h5A, 32'h0F, 3, 1);
    check("ena hold count not full at 7", 32'(uio_out[3]), 32'd0);
    shift_ops(32'hC3, 32'h5A, 32'h0F, 0, 0);
    check("ena hold count full at 8", 32'(uio_out[3]), 32'd1);
    run_op("ena hold", 1'b0, 3'd0);
    check_result("ena hold", 64'h12C);

    // 10-bit shift keeps only the last 8 bits.
    shift_ops(32'h3A5, 32'h0, 32'h0, 9, 0);
    check("overshift count_full", 32'(uio_out[3]), 32'd1);
    run_op("overshift", 1'b0, 3'd0);
    check_result("overshift", 64'hA5);

    // Reset in the middle of RUN aborts and clears everything.
    shift_ops(32'h3A5, 32'h0, 32'h0, 9, 0);
    la = 1'b1;
    step();
    check("abort launch->RUN", 32'(uio_out[1:0]), 32'd2);
    la = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int s = 0; s < 6; s++) begin
      rd(3'(s), v);
      check("abort uo_out", 32'(v), 32'h0);
    end
    check("abort uio_out", 32'(uio_out), 32'h0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("abort stays IDLE", 32'(uio_out), 32'h0);
    rd(3'd0, v); check("abort no result", 32'(v), 32'h0);

    // Two operations from reset, then the run counter readout.
    shift_ops(32'h01, 32'h02, 32'h03, 7, 0);
    run_op("count op1", 1'b0, 3'd0);
    shift_ops(32'h01, 32'h02, 32'h03, 7, 0);
    run_op("count op2", 1'b0, 3'd0);
`ifdef HARNESS_RUN_COUNTER_EN
    rd(3'd4, v); check("run count sel4", 32'(v), 32'h02);
    check("run count nibble", 32'(uio_out[7:4]), 32'h2);
`else
    rd(3'd4, v); check("run count sel4", 32'(v), 32'h00);
    check("run count nibble", 32'(uio_out[7:4]), 32'h0);
`endif
    rd(3'd5, v); check("run count sel5", 32'(v), 32'h00);

    // Randomized transactions against the arithmetic model.
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      first = 1'b1;
      nsh = $urandom_range(1, 12);
      done_sh = 0;
      while (done_sh < nsh) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          ena = 1'b0; sh = 1'($urandom); d = 3'($urandom); la = 1'($urandom);
          step();
          la = 1'b0;
        end else if (r == 1) begin
          ena = 1'b1; sh = 1'b0; d = 3'($urandom); la = 1'b0;
          step();
        end else begin
          ena = 1'b1; sh = 1'b1; d = 3'($urandom); la = 1'b0;
          step();
          model_shift(d);
          cnt = first ? 1 : ((cnt + 1 > WIDTH) ? WIDTH : cnt + 1);
          first = 1'b0;
          done_sh++;
        end
      end
      ena = 1'b1; sh = 1'b0;
      check("rand LOAD state", 32'(uio_out[1:0]), 32'd1);
      check("rand count_full", 32'(uio_out[3]), 32'(cnt == WIDTH));
      run_op("rand", 1'($urandom), 3'($urandom));
      check_result("rand", mo[0] + mo[1] + mo[2]);
      rc = exp_run();
      check("rand status", 32'(uio_out), 32'({rc[3:0], (cnt == WIDTH), 3'b111}));
    end
    rd(3'd4, v); check("rand run count lo", 32'(v), 32'(exp_run() & 16'hFF));
    rd(3'd5, v); check("rand run count hi", 32'(v), 32'(exp_run() >> 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
